eq_gain_ctrl: RTL and testbench

Gain-command sequencer that drives the equalizer's serial gain-load interface (`eq_rst`, `gainwe`, `gainset`) in `my_eq`. It sits directly upstream of the equalizer and accepts per-band gain commands from the control path (key/UART decoder) over a valid/ready handshake. It serialises each command onto `gainset` under a `gainwe` frame strobe and sequences the equalizer reset at power-up and on request. The same three outputs are the nets the on-chip analyser probes.

---
 rtl/eq_gain_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_eq_gain_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eq_gain_ctrl.sv
// Gain-command sequencer for the equalizer's serial gain-load port (eq_rst/gainwe/gainset).
// Optional shadow-gain replay after every equalizer reset is enabled by defining EQ_RELOAD_EN.
module eq_gain_ctrl #(
  parameter int              NBANDS     = 10,
  parameter int              BAND_W     = 4,
  parameter int              GAIN_W     = 8,
  parameter int              RST_CYCLES = 16,
  parameter logic [GAIN_W-1:0] GAIN_DEF = 8'h80
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_req,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [BAND_W-1:0] cmd_band,
  input  logic [GAIN_W-1:0] cmd_gain,
  output logic              eq_rst,
  output logic              gainwe,
  output logic              gainset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int FRAME = BAND_W + GAIN_W;
  localparam int BIT_W = $clog2(FRAME);
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(RST_CYCLES - 1);
  localparam logic [BAND_W:0]   BAND_LIM  = (BAND_W + 1)'(NBANDS);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NBANDS - 1);

  if (RST_CYCLES < 1 || FRAME < 2 || NBANDS < 1 || NBANDS > (1 << BAND_W) ||
      $bits(GAIN_DEF) != GAIN_W) begin : g_param_check
    $error("eq_gain_ctrl: invalid parameter set");
  end

`ifdef EQ_RELOAD_EN
  typedef enum logic [2:0] {S_RSTEQ, S_RELOAD, S_IDLE, S_SHIFT, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_RSTEQ, S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  rst_cnt_reg, rst_cnt_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [FRAME-1:0]  shift_reg, shift_next;
  logic              pend_reg, pend_next;
  logic              eq_rst_reg, eq_rst_next;
  logic              gainwe_reg, gainwe_next;
  logic              gainset_reg, gainset_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              accept, band_ok, load_frame, mid_reload;
  logic [FRAME-1:0]  frame_word;

  // init_req masks the handshake combinationally so it always wins over a same-cycle command
  assign cmd_ready = ready_reg & ~init_req;
  assign accept    = cmd_valid & cmd_ready;
  assign band_ok   = {1'b0, cmd_band} < BAND_LIM;

`ifdef EQ_RELOAD_EN
  logic [GAIN_W-1:0] shadow_rd [NBANDS];
  logic [BAND_W-1:0] reload_idx_reg, reload_idx_next;
  logic              reload_act_reg, reload_act_next;

  genvar gi;
  for (gi = 0; gi < NBANDS; gi++) begin : g_shadow
    logic [GAIN_W-1:0] gain_reg;
    always_ff @(posedge sys_clk) begin
      if (sys_rst)
        gain_reg <= GAIN_DEF;
      else if (accept && band_ok && cmd_band == BAND_W'(gi))
        gain_reg <= cmd_gain;
    end
    assign shadow_rd[gi] = gain_reg;
  end

  assign mid_reload = reload_act_reg && (reload_idx_reg != LAST_BAND);
`else
  assign mid_reload = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= S_RSTEQ;
      rst_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      pend_reg    <= 1'b0;
      eq_rst_reg  <= 1'b1;
      gainwe_reg  <= 1'b0;
      gainset_reg <= 1'b0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
`ifdef EQ_RELOAD_EN
      reload_idx_reg <= '0;
      reload_act_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      rst_cnt_reg <= rst_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      pend_reg    <= pend_next;
      eq_rst_reg  <= eq_rst_next;
      gainwe_reg  <= gainwe_next;
      gainset_reg <= gainset_next;
      ready_reg   <= ready_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
`ifdef EQ_RELOAD_EN
      reload_idx_reg <= reload_idx_next;
      reload_act_reg <= reload_act_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = rst_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    pend_next    = pend_reg;
    load_frame   = 1'b0;
    frame_word   = {cmd_band, cmd_gain};
`ifdef EQ_RELOAD_EN
    reload_idx_next = reload_idx_reg;
    reload_act_next = reload_act_reg;
`endif
    case (state_reg)
      S_RSTEQ: begin
        if (init_req) begin
          rst_cnt_next = '0;
        end else if (rst_cnt_reg == LAST_CNT) begin
          rst_cnt_next = '0;
`ifdef EQ_RELOAD_EN
          state_next      = S_RELOAD;
          reload_act_next = 1'b1;
          reload_idx_next = '0;
`else
          state_next = S_IDLE;
`endif
        end else begin
          rst_cnt_next = rst_cnt_reg + CNT_W'(1);
        end
      end
`ifdef EQ_RELOAD_EN
      S_RELOAD: begin
        frame_word = {reload_idx_reg, shadow_rd[reload_idx_reg]};
        load_frame = 1'b1;
        state_next = S_SHIFT;
        pend_next  = pend_reg | init_req;
      end
`endif
      S_IDLE: begin
        if (init_req) begin
          state_next = S_RSTEQ;
        end else if (accept && band_ok) begin
          load_frame = 1'b1;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        pend_next = pend_reg | init_req;
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = S_GAP;
        end else begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          // rotate so the register keeps every bit live; the MSB is always the bit on the wire
          shift_next   = {shift_reg[FRAME-2:0], shift_reg[FRAME-1]};
        end
      end
      S_GAP: begin
        if (pend_reg || init_req) begin
          state_next = S_RSTEQ;
          pend_next  = 1'b0;
`ifdef EQ_RELOAD_EN
          reload_act_next = 1'b0;
        end else if (mid_reload) begin
          state_next      = S_RELOAD;
          reload_idx_next = reload_idx_reg + BAND_W'(1);
`endif
        end else begin
          state_next = S_IDLE;
`ifdef EQ_RELOAD_EN
          reload_act_next = 1'b0;
`endif
        end
      end
      default: state_next = S_RSTEQ;
    endcase
    if (load_frame) begin
      shift_next   = frame_word;
      bit_cnt_next = '0;
    end
  end

  always_comb begin
    eq_rst_next  = (state_next == S_RSTEQ);
    gainwe_next  = (state_next == S_SHIFT);
    gainset_next = gainwe_next & shift_next[FRAME-1];
    busy_next    = (state_next != S_IDLE);
    ready_next   = (state_next == S_IDLE);
    done_next    = (state_reg == S_SHIFT) && (state_next == S_GAP) && !mid_reload;
    err_next     = accept && !band_ok;
  end

  assign eq_rst  = eq_rst_reg;
  assign gainwe  = gainwe_reg;
  assign gainset = gainset_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Scoreboard bench for eq_gain_ctrl: the driver pushes expected frames/errors, a monitor
// reassembles gainwe frames and err pulses and compares them in order.
module tb_eq_gain_ctrl;
  localparam int NBANDS     = 10;
  localparam int BAND_W     = 4;
  localparam int GAIN_W     = 8;
  localparam int RST_CYCLES = 16;
  localparam int FRAME      = BAND_W + GAIN_W;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              init_req = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [BAND_W-1:0] cmd_band = '0;
  logic [GAIN_W-1:0] cmd_gain = '0;
  logic              eq_rst, gainwe, gainset, busy, done, err;

  eq_gain_ctrl #(
    .NBANDS(NBANDS), .BAND_W(BAND_W), .GAIN_W(GAIN_W),
    .RST_CYCLES(RST_CYCLES), .GAIN_DEF(8'h80)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_req(init_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_band(cmd_band), .cmd_gain(cmd_gain),
    .eq_rst(eq_rst), .gainwe(gainwe), .gainset(gainset),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic             is_err;
    logic             exp_done;
    logic [FRAME-1:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  model_gain [NBANDS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBANDS; b++) model_gain[b] = 8'h80;
  endtask

  // After every equalizer reset the reload feature replays the remembered gain of each band
  task automatic push_reload();
`ifdef EQ_RELOAD_EN
    for (int b = 0; b < NBANDS; b++) begin
      logic [3:0] b4;
      b4 = 4'(b);
      exp_q.push_back('{is_err: 1'b0, exp_done: (b == NBANDS - 1), word: {b4, model_gain[b]}});
    end
`endif
  endtask

  // Monitor: reassemble each gainwe-high run into a frame word and compare with the queue head
  initial begin
    logic [FRAME-1:0] acc;
    int               nbits;
    logic             prev_we;
    logic             frame_end;
    exp_t             e;
    acc = '0; nbits = 0; prev_we = 1'b0;
    forever begin
      @(negedge sys_clk);
      frame_end = !gainwe && prev_we;
      if (gainwe) begin
        acc = {acc[FRAME-2:0], gainset};
        nbits++;
      end else if (frame_end) begin
        if (sys_rst) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame: got %03h, required no frame", acc);
        end else begin
          e = exp_q.pop_front();
          check("frame_kind", {31'd0, e.is_err}, 32'd0);
          check("frame_word", {20'd0, acc}, {20'd0, e.word});
          check("frame_len", nbits, FRAME);
          check("frame_done", {31'd0, done}, {31'd0, e.exp_done});
        end
        acc = '0;
        nbits = 0;
      end
      if (done && !frame_end) begin
        tests++; fails++;
        $display("FAIL stray_done: got done=1, required done=0");
      end
      if (err) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_err: got err=1, required err=0");
        end else begin
          e = exp_q.pop_front();
          check("err_kind", {31'd0, e.is_err}, 32'd1);
        end
      end
      prev_we = gainwe;
    end
  end

  task automatic wait_rst_seq(input string name);
    int   n;
    logic ready_ok;
    n = 0; ready_ok = 1'b1;
    while (!eq_rst && n < 200) begin
      if (cmd_ready) ready_ok = 1'b0;
      tick(); n++;
    end
    check({name, "_rst_seen"}, {31'd0, eq_rst}, 32'd1);
    n = 0;
    while (eq_rst && n < 200) begin
      if (cmd_ready) ready_ok = 1'b0;
      n++; tick();
    end
    check({name, "_rst_len"}, n, RST_CYCLES);
    check({name, "_ready_low"}, {31'd0, ready_ok}, 32'd1);
    n = 0;
    while (!cmd_ready && n < 400) begin tick(); n++; end
    check({name, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic send_cmd(input int band, input logic [7:0] gain, input bit wait_ready);
    int         n;
    logic [3:0] b4;
    b4 = 4'(band);
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_band = b4; cmd_gain = gain;
    if (band < NBANDS) begin
      exp_q.push_back('{is_err: 1'b0, exp_done: 1'b1, word: {b4, gain}});
      model_gain[band] = gain;
    end else begin
      exp_q.push_back('{is_err: 1'b1, exp_done: 1'b0, word: '0});
    end
    tick();
    cmd_valid = 1'b0;
    $display("[TB] cmd band=%0d gain=%02h", band, gain);
    if (band < NBANDS) begin
      check("frame_start", {29'd0, gainwe, busy, cmd_ready}, 32'b110);
      if (wait_ready) begin
        n = 1;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        check("accept_to_ready", n, FRAME + 2);
      end
    end else begin
      check("oor_stay_idle", {29'd0, gainwe, busy, cmd_ready}, 32'b001);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    check("rst_eq_rst", {31'd0, eq_rst}, 32'd1);
    check("rst_gainwe", {31'd0, gainwe}, 32'd0);
    check("rst_gainset", {31'd0, gainset}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    push_reload();
    sys_rst = 1'b0;
    wait_rst_seq("por");

    send_cmd(3, 8'hA5, 1'b1);
    send_cmd(12, 8'h3C, 1'b1);

    for (int i = 0; i < 16; i++) begin
      send_cmd(int'($urandom_range(0, 13)), 8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    // init_req while a frame is on the wire: frame must finish, then the reset sequence
    send_cmd(5, 8'($urandom_range(0, 255)), 1'b0);
    repeat (4) tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    $display("[TB] init_req mid-frame");
    push_reload();
    wait_rst_seq("init_mid");

    send_cmd(3, 8'hA5, 1'b1);
    cmd_valid = 1'b1; cmd_band = 4'd7; cmd_gain = 8'h11; init_req = 1'b1;
    #1;
    check("sim_init_ready", {31'd0, cmd_ready}, 32'd0);
    push_reload();
    tick();
    cmd_valid = 1'b0; init_req = 1'b0;
    $display("[TB] init_req with cmd_valid in IDLE");
    wait_rst_seq("sim_init");

    // sys_rst mid-frame: the partial frame is discarded and the reset values return at once
    send_cmd(9, 8'($urandom_range(0, 255)), 1'b0);
    repeat (6) tick();
    sys_rst = 1'b1;
    tick();
    check("midrst_gainwe", {31'd0, gainwe}, 32'd0);
    check("midrst_eq_rst", {31'd0, eq_rst}, 32'd1);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    model_reset();
    tick();
    sys_rst = 1'b0;
    $display("[TB] sys_rst mid-frame");
    push_reload();
    wait_rst_seq("rst_mid");

    send_cmd(0, 8'h5A, 1'b1);
    send_cmd(NBANDS - 1, 8'hFF, 1'b1);
    send_cmd(NBANDS, 8'h01, 1'b1);

    repeat (20) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
